note_scheduler: RTL and testbench
=================================

Name: note_scheduler

Overview:
- Sequences Guitar Villains gameplay: converts the difficulty period `diff_speed` into scroll ticks and spawns notes into a 4-lane x 8-row falling buffer.
- Scores player hits in the bottom (hit) row and counts misses until game over.
- Sits between the difficulty/speed block and the display/score drivers; active only while mode selects PLAY.

Parameters:
- ROWS, 8, rows in the falling buffer; row 0 is the hit row.
- MAX_MISS, 5, misses that end the game.
- COUNTIN_TICKS, 4, blank scroll ticks before the first spawn.
- LFSR_SEED, 16'hACE1, reset/start seed of the lane LFSR; must be nonzero.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  reset; asynchronous, active-low.
- mode  in  3  game mode; PLAY = 3'd4 (package constant).
- diff_speed  in  23  scroll period in clocks; 0 is treated as 1.
- level  in  2  EASY=1, MEDIUM=2, HARD=3; any other value behaves as EASY.
- lane_hit  in  4  one-cycle hit strobes per lane, already synchronised and edge-detected upstream.
- note_rows  out  32  row r occupies bits [4r+3:4r]; bit = note present in that lane.
- scroll_tick  out  1  one-cycle pulse, coincident with the first cycle the shifted rows are visible.
- score  out  8  hits, saturating at 255.
- misses  out  3  missed notes.
- game_over  out  1  high in OVER.
- state  out  2  IDLE=0, COUNTIN=1, PLAY=2, OVER=3.

Behaviour:
- Reset values: all outputs 0, state IDLE, LFSR = LFSR_SEED, period counter 0, spawn counter 0.
- Period counter runs only in COUNTIN and PLAY, cleared on entry to either state.
- Internal tick fires when count >= max(diff_speed,1)-1, then count reloads 0. The >= comparison makes a mid-count period decrease tick on the next cycle, never wrap.
- Registered outputs: scroll_tick, note_rows, score, misses and game_over are all registered. The edge that consumes an internal tick updates rows and raises scroll_tick together.
- IDLE -> COUNTIN when mode==PLAY. Entry clears note_rows, score, misses and spawn counter, and reloads LFSR_SEED.
- COUNTIN: each tick shifts rows down, inserting an empty top row. After COUNTIN_TICKS ticks -> PLAY.
- PLAY, per tick:
  - Rows shift toward row 0. Notes left in row 0 before the shift add popcount to misses (saturating at MAX_MISS).
  - New top row: if a spawn slot, one-hot lane = 1<<lfsr[1:0] and the LFSR advances one step; otherwise 0.
  - Spawn slots by 2-bit spawn counter (increments every PLAY tick): EASY when cnt==0, MEDIUM when cnt[0]==0, HARD every tick.
  - LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts toward MSB, feedback into bit 0.
- PLAY, per cycle: for each lane with lane_hit & row0 bit set, clear the bit and add 1 to score. Multiple simultaneous lanes each score.
  - Strobes on empty lanes are ignored.
  - Strobes in IDLE, COUNTIN and OVER are ignored.
- Hit and tick in the same cycle: the hit is evaluated against the pre-shift row 0. The hit note scores and is not counted as a miss. The remaining unhit row-0 notes count as misses.
- Game over: when misses reaches MAX_MISS -> OVER on the same edge. In OVER, rows freeze, ticks stop, game_over=1, and score/misses are held.
- Mode change: mode != PLAY in any state -> IDLE next edge. Rows clear; score and misses are held for display until the next COUNTIN entry.
- Level is sampled each tick. A change only alters subsequent spawn slots.

Decomposition:
- Package gv_pkg: mode constants (DIFF=3'd3, PLAY=3'd4), level constants (EASY/MEDIUM/HARD), state_t enum, LFSR taps and seed default.
- Sub-module tick_gen: period counter with enable, synchronous clear and >= compare; outputs the internal tick.
- LFSR, spawn logic, row buffer and scoring stay in note_scheduler.

Test Plan:
1. Reset, mode=4, diff_speed=10, level=3 -> state 1, then scroll_tick every 10 clocks. First nonzero top row appears on tick 5, lane = 1<<(16'hACE1 & 3) = lane 1 (row 7 = 4'b0010).
2. Same setup, pulse lane_hit=4'b0010 when row0=4'b0010 -> score 1, row0 bit cleared. The next tick adds no miss.
3. level=1, diff_speed=4, no hits -> a spawn on every 4th PLAY tick. misses increments as each note exits row 0. At misses=5, game_over=1, state 3, and rows stop changing.
4. Hit strobe on the exact cycle of an internal tick with row0=4'b0010, lane_hit=4'b0010 -> score +1, misses unchanged. Hit strobe on an empty lane -> no change.
5. Mid-PLAY, mode=3 -> state 0 next cycle, note_rows=0, score held. Re-enter PLAY -> score 0 and the identical spawn sequence repeats.
6. diff_speed=0 -> tick every clock. diff_speed changed from 100 to 5 at count 50 -> tick on the next clock. Assert n_rst mid-PLAY -> all outputs 0 immediately.

Source files
------------

// File: rtl/gv_pkg.sv
// Shared constants, state encoding and small helpers for the note scheduler.
// Pure declarations: no latency and no flow control.
package gv_pkg;

  localparam logic [2:0] MODE_DIFF = 3'd3;
  localparam logic [2:0] MODE_PLAY = 3'd4;

  localparam logic [1:0] LVL_EASY   = 2'd1;
  localparam logic [1:0] LVL_MEDIUM = 2'd2;
  localparam logic [1:0] LVL_HARD   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNTIN = 2'd1,
    ST_PLAY    = 2'd2,
    ST_OVER    = 2'd3
  } state_t;

  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward the MSB.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Scroll period counter: combinational tick when count >= max(period,1)-1, then reload.
// Tick is valid in the same cycle the compare holds; no backpressure, runs only while en.
module tick_gen (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        en,
  input  logic        clr,
  input  logic [22:0] period,
  output logic        tick
);

  logic [22:0] cnt_q;
  logic [22:0] cnt_d;
  logic [22:0] limit;

  // >= rather than == so a shortened period mid-count ticks at once instead of wrapping.
  always_comb begin
    limit = (period == 23'd0) ? 23'd0 : period - 23'd1;
    tick  = en && (cnt_q >= limit);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 23'd0;
    end else if (tick) begin
      cnt_d = 23'd0;
    end else if (en) begin
      cnt_d = cnt_q + 23'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= 23'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/note_scheduler.sv
// Spawns notes into a 4-lane falling buffer on scroll ticks, scores hits in row 0, counts misses.
// All outputs registered (one edge after the tick/hit); no backpressure, hit strobes are single-cycle.
module note_scheduler
  import gv_pkg::*;
#(
  parameter int          ROWS          = 8,
  parameter int          MAX_MISS      = 5,
  parameter int          COUNTIN_TICKS = 4,
  parameter logic [15:0] LFSR_SEED     = LFSR_SEED_DEFAULT
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [2:0]          mode,
  input  logic [22:0]         diff_speed,
  input  logic [1:0]          level,
  input  logic [3:0]          lane_hit,
  output logic [4*ROWS-1:0]   note_rows,
  output logic                scroll_tick,
  output logic [7:0]          score,
  output logic [2:0]          misses,
  output logic                game_over,
  output logic [1:0]          state
);

  localparam int RW = 4 * ROWS;
  localparam int CW = $clog2(COUNTIN_TICKS + 1);

  state_t        state_q, state_d;
  logic [RW-1:0] rows_q, rows_d;
  logic [7:0]    score_q, score_d;
  logic [2:0]    misses_q, misses_d;
  logic          game_over_q, game_over_d;
  logic          scroll_tick_q, scroll_tick_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [1:0]    spawn_cnt_q, spawn_cnt_d;
  logic [CW-1:0] ctin_q, ctin_d;

  logic          tick;
  logic          tick_en;
  logic          tick_clr;
  logic [3:0]    row0;
  logic [3:0]    hit;
  logic [3:0]    top_row;
  logic          spawn_slot;
  logic [RW-1:0] rows_hit;
  logic [8:0]    score_sum;
  logic [3:0]    miss_sum;

  assign tick_en = (state_q == ST_COUNTIN) || (state_q == ST_PLAY);

  tick_gen u_tick_gen (
    .clk    (clk),
    .n_rst  (n_rst),
    .en     (tick_en),
    .clr    (tick_clr),
    .period (diff_speed),
    .tick   (tick)
  );

  always_comb begin
    state_d       = state_q;
    rows_d        = rows_q;
    score_d       = score_q;
    misses_d      = misses_q;
    lfsr_d        = lfsr_q;
    spawn_cnt_d   = spawn_cnt_q;
    ctin_d        = ctin_q;
    scroll_tick_d = 1'b0;
    tick_clr      = 1'b0;
    row0          = rows_q[3:0];
    hit           = 4'd0;
    top_row       = 4'd0;
    rows_hit      = rows_q;
    score_sum     = 9'd0;
    miss_sum      = 4'd0;

    case (level)
      LVL_HARD:   spawn_slot = 1'b1;
      LVL_MEDIUM: spawn_slot = !spawn_cnt_q[0];
      default:    spawn_slot = (spawn_cnt_q == 2'd0);
    endcase

    if (mode != MODE_PLAY) begin
      // Score and misses stay visible until the next game starts.
      state_d = ST_IDLE;
      rows_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d     = ST_COUNTIN;
          rows_d      = '0;
          score_d     = 8'd0;
          misses_d    = 3'd0;
          spawn_cnt_d = 2'd0;
          ctin_d      = '0;
          lfsr_d      = LFSR_SEED;
          tick_clr    = 1'b1;
        end
        ST_COUNTIN: begin
          if (tick) begin
            scroll_tick_d = 1'b1;
            rows_d        = {4'd0, rows_q[RW-1:4]};
            ctin_d        = ctin_q + CW'(1);
            if (ctin_q == CW'(COUNTIN_TICKS - 1)) begin
              state_d  = ST_PLAY;
              tick_clr = 1'b1;
            end
          end
        end
        ST_PLAY: begin
          // Hits resolve against pre-shift row 0, so a hit on a tick edge is never a miss.
          hit       = lane_hit & row0;
          rows_hit  = rows_q & ~{{(RW-4){1'b0}}, hit};
          score_sum = {1'b0, score_q} + 9'(popcount4(hit));
          score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
          rows_d    = rows_hit;
          if (tick) begin
            scroll_tick_d = 1'b1;
            miss_sum      = {1'b0, misses_q} + {1'b0, popcount4(row0 & ~hit)};
            if (miss_sum >= 4'(MAX_MISS)) begin
              misses_d = 3'(MAX_MISS);
              state_d  = ST_OVER;
            end else begin
              misses_d = miss_sum[2:0];
            end
            if (spawn_slot) begin
              top_row = 4'd1 << lfsr_q[1:0];
              lfsr_d  = lfsr_next(lfsr_q);
            end
            rows_d      = {top_row, rows_hit[RW-1:4]};
            spawn_cnt_d = spawn_cnt_q + 2'd1;
          end
        end
        default: begin
          state_d = ST_OVER;
        end
      endcase
    end

    game_over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= ST_IDLE;
      rows_q        <= '0;
      score_q       <= 8'd0;
      misses_q      <= 3'd0;
      game_over_q   <= 1'b0;
      scroll_tick_q <= 1'b0;
      lfsr_q        <= LFSR_SEED;
      spawn_cnt_q   <= 2'd0;
      ctin_q        <= '0;
    end else begin
      state_q       <= state_d;
      rows_q        <= rows_d;
      score_q       <= score_d;
      misses_q      <= misses_d;
      game_over_q   <= game_over_d;
      scroll_tick_q <= scroll_tick_d;
      lfsr_q        <= lfsr_d;
      spawn_cnt_q   <= spawn_cnt_d;
      ctin_q        <= ctin_d;
    end
  end

  assign note_rows   = rows_q;
  assign scroll_tick = scroll_tick_q;
  assign score       = score_q;
  assign misses      = misses_q;
  assign game_over   = game_over_q;
  assign state       = state_q;

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler; expected values hand-derived from the LFSR lane sequence 1,3,3,3,2,0,1,2,0,0.
module tb_note_scheduler;
  import gv_pkg::*;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [2:0]  mode;
  logic [22:0] diff_speed;
  logic [1:0]  level;
  logic [3:0]  lane_hit;
  logic [31:0] note_rows;
  logic        scroll_tick;
  logic [7:0]  score;
  logic [2:0]  misses;
  logic        game_over;
  logic [1:0]  state;

  int checks   = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  note_scheduler dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .mode        (mode),
    .diff_speed  (diff_speed),
    .level       (level),
    .lane_hit    (lane_hit),
    .note_rows   (note_rows),
    .scroll_tick (scroll_tick),
    .score       (score),
    .misses      (misses),
    .game_over   (game_over),
    .state       (state)
  );

  task automatic step(input int cnt);
    repeat (cnt) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance until scroll_tick is seen, bounded; returns cycles taken.
  task automatic wait_tick(input int bound, output int cyc);
    cyc = 0;
    do begin
      step(1);
      cyc++;
    end while (scroll_tick !== 1'b1 && cyc < bound);
    chk("tick_seen", 32'(scroll_tick), 32'd1);
  endtask

  initial begin
    n_rst      = 1'b0;
    mode       = 3'd0;
    diff_speed = 23'd10;
    level      = LVL_HARD;
    lane_hit   = 4'd0;
    step(2);
    chk("rst_rows", note_rows, 32'h0);
    chk("rst_tick", 32'(scroll_tick), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_misses", 32'(misses), 32'd0);
    chk("rst_over", 32'(game_over), 32'd0);
    chk("rst_state", 32'(state), 32'd0);

    // Start: count-in with period 10, first spawn on tick 5 in lane 1.
    n_rst = 1'b1;
    mode  = MODE_PLAY;
    step(1);
    chk("enter_countin", 32'(state), 32'd1);
    for (int i = 0; i < 4; i++) begin
      wait_tick(20, n);
      chk("period10", 32'(n), 32'd10);
    end
    chk("play_state", 32'(state), 32'd2);
    chk("countin_rows_empty", note_rows, 32'h0);
    wait_tick(20, n);
    chk("first_spawn", note_rows, 32'h2000_0000);
    repeat (7) wait_tick(20, n);
    chk("hard_fill", note_rows, 32'h4214_8882);

    // Hit in row 0 between ticks.
    lane_hit = 4'b0010;
    step(1);
    lane_hit = 4'd0;
    chk("hit_score", 32'(score), 32'd1);
    chk("hit_clear", note_rows, 32'h4214_8880);
    wait_tick(20, n);
    chk("tick_after_hit_cycles", 32'(n), 32'd9);
    chk("rows_after_hit", note_rows, 32'h1421_4888);
    chk("no_miss_after_hit", 32'(misses), 32'd0);

    // Hit coincident with the tick edge.
    step(9);
    lane_hit = 4'b1000;
    step(1);
    lane_hit = 4'd0;
    chk("tick_hit_tick", 32'(scroll_tick), 32'd1);
    chk("tick_hit_score", 32'(score), 32'd2);
    chk("tick_hit_misses", 32'(misses), 32'd0);
    chk("tick_hit_rows", note_rows, 32'h1142_1488);
    lane_hit = 4'b0001;
    step(1);
    lane_hit = 4'd0;
    chk("empty_lane_score", 32'(score), 32'd2);
    chk("empty_lane_rows", note_rows, 32'h1142_1488);
    wait_tick(20, n);
    chk("miss_counted", 32'(misses), 32'd1);
    chk("miss_score_held", 32'(score), 32'd2);

    // Leave PLAY mode, then re-enter: same spawn sequence.
    mode = MODE_DIFF;
    step(1);
    chk("leave_state", 32'(state), 32'd0);
    chk("leave_rows", note_rows, 32'h0);
    chk("leave_score_held", 32'(score), 32'd2);
    chk("leave_misses_held", 32'(misses), 32'd1);
    mode = MODE_PLAY;
    step(1);
    chk("reenter_state", 32'(state), 32'd1);
    chk("reenter_score", 32'(score), 32'd0);
    chk("reenter_misses", 32'(misses), 32'd0);
    repeat (5) wait_tick(20, n);
    chk("repeat_spawn1", note_rows, 32'h2000_0000);
    wait_tick(20, n);
    chk("repeat_spawn2", note_rows, 32'h8200_0000);

    // EASY at period 4, no hits, until game over.
    mode = MODE_DIFF;
    step(1);
    diff_speed = 23'd4;
    level      = LVL_EASY;
    mode       = MODE_PLAY;
    step(1);
    repeat (4) wait_tick(10, n);
    chk("easy_play_state", 32'(state), 32'd2);
    for (int t = 1; t <= 25; t++) begin
      wait_tick(10, n);
      if (t == 1) chk("easy_t1_rows", note_rows, 32'h2000_0000);
      if (t == 8) chk("easy_t8_rows", note_rows, 32'h0008_0002);
      if (t == 9) chk("easy_t9_misses", 32'(misses), 32'd1);
      if (t == 24) begin
        chk("easy_t24_misses", 32'(misses), 32'd4);
        chk("easy_t24_state", 32'(state), 32'd2);
      end
      if (t == 25) begin
        chk("over_misses", 32'(misses), 32'd5);
        chk("over_flag", 32'(game_over), 32'd1);
        chk("over_state", 32'(state), 32'd3);
        chk("over_rows", note_rows, 32'h2000_1000);
      end
    end
    step(12);
    chk("over_rows_frozen", note_rows, 32'h2000_1000);
    chk("over_no_tick", 32'(scroll_tick), 32'd0);
    chk("over_state_held", 32'(state), 32'd3);

    // diff_speed 0 ticks every clock.
    mode = MODE_DIFF;
    step(1);
    diff_speed = 23'd0;
    level      = LVL_HARD;
    mode       = MODE_PLAY;
    step(1);
    wait_tick(5, n);
    chk("speed0_first", 32'(n), 32'd1);
    wait_tick(5, n);
    chk("speed0_second", 32'(n), 32'd1);

    // Period shortened mid-count ticks on the next clock.
    mode = MODE_DIFF;
    step(1);
    diff_speed = 23'd100;
    mode       = MODE_PLAY;
    step(1);
    step(50);
    chk("long_period_no_tick", 32'(scroll_tick), 32'd0);
    diff_speed = 23'd5;
    step(1);
    chk("shrink_tick_next", 32'(scroll_tick), 32'd1);
    wait_tick(20, n);
    chk("period5", 32'(n), 32'd5);
    repeat (2) wait_tick(20, n);
    chk("speed_play_state", 32'(state), 32'd2);
    wait_tick(20, n);
    chk("speed_spawn", note_rows, 32'h2000_0000);

    // Asynchronous reset mid-PLAY.
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst_rows", note_rows, 32'h0);
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_tick", 32'(scroll_tick), 32'd0);
    chk("arst_over", 32'(game_over), 32'd0);
    chk("arst_misses", 32'(misses), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
